// File: rtl/qnigma_oper_loader.sv
// Operand loader for the qnigma_alu operand RAM: queues whole field operands
// and streams each as RAM words, most-significant word first, with no gaps.
module qnigma_oper_loader #(
    parameter int OPER_W    = 256,
    parameter int WRD_W     = 32,
    parameter int PTR_W     = 8,
    parameter int NW_F25519 = 8,
    parameter int NW_F1305  = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_val,
    output logic              req_rdy,
    input  logic [OPER_W-1:0] req_oper,
    input  logic [PTR_W-1:0]  req_ptr,
    input  logic              req_fld,
    output logic [WRD_W-1:0]  ext_wr_dat,
    output logic [PTR_W-1:0]  ext_wr_ptr,
    output logic              ext_wr_val,
    output logic              ext_wr_sof,
    output logic              ext_wr_eof,
    output logic              done,
    output logic              trunc_err,
    output logic              busy
);

    localparam int IDX_W = (NW_F25519 > 1) ? $clog2(NW_F25519) : 1;
    localparam logic [IDX_W-1:0] TOP_F25519 = IDX_W'(NW_F25519 - 1);
    localparam logic [IDX_W-1:0] TOP_F1305  = IDX_W'(NW_F1305 - 1);

    typedef enum logic {
        ST_IDLE,
        ST_STREAM
    } state_t;

    state_t state;

    // Two-entry request queue.
    logic [OPER_W-1:0] q_oper [2];
    logic [PTR_W-1:0]  q_ptr  [2];
    logic              q_fld  [2];
    logic              wr_sel;
    logic              rd_sel;
    logic [1:0]        count;
    logic              rst_q;

    logic [OPER_W-1:0] hold_oper;
    logic [IDX_W-1:0]  idx;

    logic              push;
    logic              pop;
    logic [OPER_W-1:0] head_oper;
    logic [PTR_W-1:0]  head_ptr;
    logic              head_fld;
    logic [IDX_W-1:0]  head_top;
    logic              head_trunc;

    // rst_q keeps req_rdy low during reset and for the release edge itself.
    assign req_rdy = ~rst_q & (count != 2'd2);
    assign push    = req_val & req_rdy;
    assign busy    = (count != 2'd0) | (state == ST_STREAM);

    always_comb begin
        head_oper  = q_oper[rd_sel];
        head_ptr   = q_ptr[rd_sel];
        head_fld   = q_fld[rd_sel];
        head_top   = head_fld ? TOP_F25519 : TOP_F1305;
        head_trunc = ~head_fld && ((head_oper >> (NW_F1305 * WRD_W)) != '0);
        // A new operand starts from idle or right after the previous eof word.
        pop        = (count != 2'd0) && ((state == ST_IDLE) || ext_wr_eof);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rst_q  <= 1'b1;
            wr_sel <= 1'b0;
            rd_sel <= 1'b0;
            count  <= 2'd0;
        end else begin
            rst_q <= 1'b0;
            if (push) begin
                q_oper[wr_sel] <= req_oper;
                q_ptr[wr_sel]  <= req_ptr;
                q_fld[wr_sel]  <= req_fld;
                wr_sel         <= ~wr_sel;
            end
            if (pop)
                rd_sel <= ~rd_sel;
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            hold_oper  <= '0;
            idx        <= '0;
            ext_wr_dat <= '0;
            ext_wr_ptr <= '0;
            ext_wr_val <= 1'b0;
            ext_wr_sof <= 1'b0;
            ext_wr_eof <= 1'b0;
            done       <= 1'b0;
            trunc_err  <= 1'b0;
        end else begin
            ext_wr_sof <= 1'b0;
            ext_wr_eof <= 1'b0;
            done       <= 1'b0;
            trunc_err  <= 1'b0;
            if (pop) begin
                // First word comes straight from the queue head so the sof
                // word lands one cycle after the pop.
                state      <= ST_STREAM;
                hold_oper  <= head_oper;
                idx        <= head_top - IDX_W'(1);
                ext_wr_dat <= head_oper[int'(head_top) * WRD_W +: WRD_W];
                ext_wr_ptr <= head_ptr;
                ext_wr_val <= 1'b1;
                ext_wr_sof <= 1'b1;
                ext_wr_eof <= (head_top == '0);
                done       <= (head_top == '0);
                trunc_err  <= head_trunc;
            end else if (state == ST_STREAM && !ext_wr_eof) begin
                ext_wr_dat <= hold_oper[int'(idx) * WRD_W +: WRD_W];
                ext_wr_val <= 1'b1;
                ext_wr_eof <= (idx == '0);
                done       <= (idx == '0);
                idx        <= idx - IDX_W'(1);
            end else begin
                state      <= ST_IDLE;
                ext_wr_val <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_qnigma_oper_loader.sv
// Directed bench for qnigma_oper_loader: table of single operands plus
// hand-written sequences for queue chaining and mid-stream reset.
module tb_qnigma_oper_loader;

    logic         clk = 1'b0;
    logic         rst;
    logic         req_val;
    logic         req_rdy;
    logic [255:0] req_oper;
    logic [7:0]   req_ptr;
    logic         req_fld;
    logic [31:0]  ext_wr_dat;
    logic [7:0]   ext_wr_ptr;
    logic         ext_wr_val;
    logic         ext_wr_sof;
    logic         ext_wr_eof;
    logic         done;
    logic         trunc_err;
    logic         busy;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    qnigma_oper_loader dut (
        .clk        (clk),
        .rst        (rst),
        .req_val    (req_val),
        .req_rdy    (req_rdy),
        .req_oper   (req_oper),
        .req_ptr    (req_ptr),
        .req_fld    (req_fld),
        .ext_wr_dat (ext_wr_dat),
        .ext_wr_ptr (ext_wr_ptr),
        .ext_wr_val (ext_wr_val),
        .ext_wr_sof (ext_wr_sof),
        .ext_wr_eof (ext_wr_eof),
        .done       (done),
        .trunc_err  (trunc_err),
        .busy       (busy)
    );

    typedef struct {
        logic         fld;
        logic [7:0]   ptr;
        logic [255:0] oper;
        int           n;
        logic [31:0]  msw;
        logic [31:0]  lsw;
        logic         trunc;
    } vec_t;

    vec_t vecs [6];

    localparam logic [255:0] PAT = 256'h00000008_00000007_00000006_00000005_00000004_00000003_00000002_00000001;

    task automatic check(input string name, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    // Monitor for the chained-request sequence.
    logic mon_en   = 1'b0;
    logic mon_seen = 1'b0;
    logic mon_prev = 1'b0;
    int   mon_cnt  = 0;
    int   mon_gaps = 0;
    int   mon_done = 0;
    int   mon_p50  = 0;
    int   mon_p64  = 0;
    int   mon_p74  = 0;

    always @(negedge clk) begin
        if (mon_en) begin
            if (ext_wr_val) begin
                if (mon_seen && !mon_prev) mon_gaps++;
                mon_seen = 1'b1;
                mon_cnt++;
                if (ext_wr_ptr == 8'd50) mon_p50++;
                if (ext_wr_ptr == 8'd64) mon_p64++;
                if (ext_wr_ptr == 8'd74) mon_p74++;
            end
            if (done) mon_done++;
            mon_prev = ext_wr_val;
        end
    end

    initial begin
        logic [255:0] op;
        logic [31:0]  exp_w;
        logic         last_ok;
        int           vals;
        int           dones;

        vecs[0] = '{1'b1, 8'd50,  PAT, 8, 32'h8, 32'h1, 1'b0};
        vecs[1] = '{1'b0, 8'd64,  (256'd1 << 130) - 256'd6, 5, 32'h3, 32'hFFFFFFFA, 1'b0};
        vecs[2] = '{1'b0, 8'd10,  (256'd1 << 200) | 256'h55, 5, 32'h0, 32'h55, 1'b1};
        vecs[3] = '{1'b1, 8'd255, {256{1'b1}}, 8, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0};
        vecs[4] = '{1'b0, 8'd7,   (256'd1 << 160) | 256'h3, 5, 32'h0, 32'h3, 1'b1};
        vecs[5] = '{1'b0, 8'd8,   (256'd1 << 159), 5, 32'h80000000, 32'h0, 1'b0};

        rst = 1'b1; req_val = 1'b0; req_oper = '0; req_ptr = '0; req_fld = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_val",  ext_wr_val, 0);
        check("rst_dat",  ext_wr_dat, 0);
        check("rst_busy", busy, 0);
        check("rst_rdy",  req_rdy, 0);
        rst = 1'b0;
        @(negedge clk);
        check("rdy_after_release", req_rdy, 1);

        for (int v = 0; v < 6; v++) begin
            op       = vecs[v].oper;
            req_val  = 1'b1;
            req_oper = op;
            req_ptr  = vecs[v].ptr;
            req_fld  = vecs[v].fld;
            check("vec_rdy", req_rdy, 1);
            @(negedge clk);
            req_val = 1'b0;
            check("vec_latency_val", ext_wr_val, 0);
            check("vec_busy_queued", busy, 1);
            for (int j = 0; j < vecs[v].n; j++) begin
                @(negedge clk);
                exp_w = op[(vecs[v].n - 1 - j) * 32 +: 32];
                if (j == 0) check("vec_msw", ext_wr_dat, vecs[v].msw);
                if (j == vecs[v].n - 1) check("vec_lsw", ext_wr_dat, vecs[v].lsw);
                check("vec_word", ext_wr_dat, exp_w);
                check("vec_ptr",  ext_wr_ptr, vecs[v].ptr);
                check("vec_val",  ext_wr_val, 1);
                check("vec_sof",  ext_wr_sof, j == 0);
                check("vec_eof",  ext_wr_eof, j == vecs[v].n - 1);
                check("vec_done", done, j == vecs[v].n - 1);
                check("vec_trunc", trunc_err, (j == 0) && vecs[v].trunc);
            end
            @(negedge clk);
            check("vec_end_val",  ext_wr_val, 0);
            check("vec_end_eof",  ext_wr_eof, 0);
            check("vec_end_done", done, 0);
            check("vec_end_hold", ext_wr_dat, vecs[v].lsw);
            check("vec_end_ptr",  ext_wr_ptr, vecs[v].ptr);
            @(negedge clk);
            check("vec_idle_busy", busy, 0);
        end

        // Three back-to-back F25519 requests.
        mon_en   = 1'b1;
        req_fld  = 1'b1;
        req_oper = PAT;
        req_val  = 1'b1;
        req_ptr  = 8'd50;
        check("q_rdy0", req_rdy, 1);
        @(negedge clk);
        req_ptr  = 8'd64;
        req_oper = ~PAT;
        check("q_rdy1", req_rdy, 1);
        @(negedge clk);
        req_ptr  = 8'd74;
        req_oper = PAT;
        check("q_rdy2", req_rdy, 1);
        @(negedge clk);
        req_val = 1'b0;
        check("q_full_rdy", req_rdy, 0);
        for (int k = 2; k <= 40; k++) begin
            @(negedge clk);
            if (k == 7) check("q_rdy_before_pop", req_rdy, 0);
            if (k == 8) check("q_rdy_after_pop", req_rdy, 1);
        end
        mon_en = 1'b0;
        check("q_words", mon_cnt, 24);
        check("q_gaps",  mon_gaps, 0);
        check("q_done",  mon_done, 3);
        check("q_p50",   mon_p50, 8);
        check("q_p64",   mon_p64, 8);
        check("q_p74",   mon_p74, 8);
        check("q_idle_busy", busy, 0);

        // Reset on the 4th word with a second request queued behind it.
        req_fld = 1'b1; req_oper = PAT; req_ptr = 8'd50; req_val = 1'b1;
        @(negedge clk);
        req_ptr = 8'd64;
        @(negedge clk);
        req_val = 1'b0;
        check("r_word1", ext_wr_dat, 32'h8);
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        check("r_word4", ext_wr_dat, 32'h5);
        check("r_word4_val", ext_wr_val, 1);
        rst = 1'b1;
        @(negedge clk);
        check("r_val",  ext_wr_val, 0);
        check("r_busy", busy, 0);
        check("r_done", done, 0);
        rst = 1'b0;
        @(negedge clk);
        check("r_rdy",  req_rdy, 1);
        vals = 0; dones = 0;
        last_ok = 1'b1;
        for (int k = 0; k < 12; k++) begin
            if (ext_wr_val) vals++;
            if (done) dones++;
            if (busy) last_ok = 1'b0;
            @(negedge clk);
        end
        check("r_no_words", vals, 0);
        check("r_no_done",  dones, 0);
        check("r_flushed",  last_ok, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
